multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS-subset datapath. It replaces the single-cycle decode with a 5-state FSM (IF/ID/EX/MEM/WB) so one shared memory port serves both instruction fetch and data access. It drives all datapath mux selects and write enables each cycle, and stalls on a memory-ready handshake. Decoding covers add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lui, lw, sw, beq, bne, j and jal.

Parameters:
MEM_WAIT_MAX, 15, debug watchdog; Timeout asserts after this many consecutive cycles of Mrdy=0 in one state.

Ports:
Clk  input  1  system clock, rising edge
Clr  input  1  reset, synchronous, active-high
Op  input  6  Inst[31:26] from instruction register
Func  input  6  Inst[5:0] from instruction register
Zero  input  1  ALU zero flag (combinational, current cycle)
Mrdy  input  1  memory ready; access completes on the edge where Mrdy=1
Pcwrite  output  1  PC load enable
Irwrite  output  1  instruction register load enable
Iord  output  1  memory address select: 0=PC, 1=Aluout
Mrd  output  1  memory read request
Wmem  output  1  memory write request
Wreg  output  1  register file write enable
Regrt  output  1  dest select: 1=rt, 0=rd
Reg2reg  output  1  write-back select: 1=memory data, 0=Aluout
Jal  output  1  force dest=31 and data=PC
Se  output  1  sign-extend immediate (0 for andi/ori/xori)
Alusrca  output  2  ALU A: 00=PC, 01=rs, 10=shamt
Alusrcb  output  2  ALU B: 00=rt, 01=const 4, 10=imm, 11=imm<<2
Aluc  output  4  x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui, 0011 sll, 0111 srl, 1111 sra
Pcsrc  output  2  next PC: 00=ALU, 01=Aluout, 10=rs, 11=jump target
State  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4
Illegal  output  1  one-cycle pulse in ID for an undecoded opcode/func
Timeout  output  1  sticky watchdog flag, cleared only by Clr

Behaviour:
- Reset: on an edge with Clr=1, State<=IF, wait counter<=0, Timeout<=0. While Clr=1, all enables (Pcwrite, Irwrite, Mrd, Wmem, Wreg) are forced to 0. Selects and Aluc are 0. Asserting Clr mid-instruction aborts it with no further writes.
- Outputs are combinational from State and Op/Func. Aluout is assumed latched by the datapath every cycle.
- IF: Mrd=1, Iord=0, Alusrca=00, Alusrcb=01, Aluc=add, Pcsrc=00. If Mrdy=1: Irwrite=1, Pcwrite=1, go to ID. Otherwise stay with all enables low except Mrd.
- ID: Alusrca=00, Alusrcb=11, Aluc=add (branch target into Aluout).
  - j: Pcwrite=1, Pcsrc=11, go to IF.
  - jal: same as j, plus Wreg=1, Jal=1.
  - jr: Pcwrite=1, Pcsrc=10, go to IF.
  - Illegal opcode/func: Illegal=1, go to IF (treated as nop).
  - Otherwise go to EX.
- EX:
  - R-type: Alusrca=01 (10 for shifts), Alusrcb=00, go to WB.
  - I-type ALU and lw/sw: Alusrca=01, Alusrcb=10, go to WB (I-type) or MEM (lw/sw).
  - beq/bne: Alusrcb=00, Aluc=sub. If taken (beq&Zero or bne&!Zero): Pcwrite=1, Pcsrc=01. Go to IF either way.
- MEM: Iord=1.
  - lw: Mrd=1. On Mrdy=1 go to WB.
  - sw: Wmem=1 held until Mrdy=1, then go to IF.
  - Mrd and Wmem are never both 1.
- WB: Wreg=1. Regrt=1 for I-type, 0 for R-type. Reg2reg=1 only for lw. Go to IF.
- Latency with Mrdy held at 1: j/jal/jr 2, branch 3, R/I-type 4, sw 4, lw 5. Each Mrdy=0 cycle in IF or MEM adds one cycle.
- Watchdog: the wait counter increments on each Mrdy=0 cycle in IF or MEM and clears on any state change. Timeout sets when the count reaches MEM_WAIT_MAX. The FSM keeps waiting; it never self-aborts.
- State values 5–7 are unreachable. If entered, go to IF next edge with all enables low.

Test Plan:
- Reset: hold Clr=1 for 2 cycles with Mrdy=1 -> State=0, all enables 0, Timeout=0; first IF after release shows Mrd=1.
- add (Op=0, Func=0x20), Mrdy=1 -> State sequence 0,1,2,4,0; Wreg=1 only in WB with Regrt=0; Pcwrite only in IF.
- lw (Op=0x23), Mrdy low for 2 cycles in MEM -> MEM lasts 3 cycles with Mrd=1, Iord=1; WB has Reg2reg=1; total 7 cycles.
- beq (Op=0x04): Zero=1 -> Pcwrite=1, Pcsrc=01 in EX; repeat with Zero=0 -> Pcwrite=0; both return to IF after 3 cycles.
- jal (Op=0x03) -> in ID: Pcwrite=1, Pcsrc=11, Wreg=1, Jal=1; next cycle State=0.
- Illegal Op=0x3F -> Illegal pulses 1 cycle in ID with no writes. Separately: Mrdy=0 for 16 cycles in IF with MEM_WAIT_MAX=15 -> Timeout=1. Separately: Clr asserted during MEM of sw -> Wmem=0 that cycle and State=0 next.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle sequencer for the MIPS-subset datapath: decodes Op/Func and
// drives every mux select and write enable, stalling IF/MEM on the memory handshake.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       Mrdy,
    output logic       Pcwrite,
    output logic       Irwrite,
    output logic       Iord,
    output logic       Mrd,
    output logic       Wmem,
    output logic       Wreg,
    output logic       Regrt,
    output logic       Reg2reg,
    output logic       Jal,
    output logic       Se,
    output logic [1:0] Alusrca,
    output logic [1:0] Alusrcb,
    output logic [3:0] Aluc,
    output logic [1:0] Pcsrc,
    output logic [2:0] State,
    output logic       Illegal,
    output logic       Timeout
);

    localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W:0] CNT_LIM = (CNT_W + 1)'(MEM_WAIT_MAX);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             waiting;

    logic       is_rtype, is_legal, is_shift, is_itype, is_zext;
    logic       is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;
    logic [3:0] ex_aluc;
    logic [1:0] ex_srca, ex_srcb;
    logic       br_taken;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        is_rtype = (Op == 6'h00);
        is_legal = 1'b1;
        is_shift = 1'b0;
        is_itype = 1'b0;
        is_zext  = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        ex_aluc  = ALU_ADD;
        if (is_rtype) begin
            case (Func)
                6'h20:   ex_aluc = ALU_ADD;
                6'h22:   ex_aluc = ALU_SUB;
                6'h24:   ex_aluc = ALU_AND;
                6'h25:   ex_aluc = ALU_OR;
                6'h26:   ex_aluc = ALU_XOR;
                6'h00:   begin ex_aluc = ALU_SLL; is_shift = 1'b1; end
                6'h02:   begin ex_aluc = ALU_SRL; is_shift = 1'b1; end
                6'h03:   begin ex_aluc = ALU_SRA; is_shift = 1'b1; end
                6'h08:   is_jr = 1'b1;
                default: is_legal = 1'b0;
            endcase
        end else begin
            case (Op)
                6'h08:   is_itype = 1'b1;
                6'h0C:   begin is_itype = 1'b1; is_zext = 1'b1; ex_aluc = ALU_AND; end
                6'h0D:   begin is_itype = 1'b1; is_zext = 1'b1; ex_aluc = ALU_OR;  end
                6'h0E:   begin is_itype = 1'b1; is_zext = 1'b1; ex_aluc = ALU_XOR; end
                6'h0F:   begin is_itype = 1'b1; ex_aluc = ALU_LUI; end
                6'h23:   is_lw = 1'b1;
                6'h2B:   is_sw = 1'b1;
                6'h04:   begin is_beq = 1'b1; ex_aluc = ALU_SUB; end
                6'h05:   begin is_bne = 1'b1; ex_aluc = ALU_SUB; end
                6'h02:   is_j = 1'b1;
                6'h03:   is_jal = 1'b1;
                default: is_legal = 1'b0;
            endcase
        end
    end

    assign ex_srca  = is_shift ? 2'b10 : 2'b01;
    assign ex_srcb  = (is_itype || is_lw || is_sw) ? 2'b10 : 2'b00;
    assign br_taken = (is_beq && Zero) || (is_bne && !Zero);

    always_comb begin
        Pcwrite    = 1'b0;
        Irwrite    = 1'b0;
        Iord       = 1'b0;
        Mrd        = 1'b0;
        Wmem       = 1'b0;
        Wreg       = 1'b0;
        Regrt      = 1'b0;
        Reg2reg    = 1'b0;
        Jal        = 1'b0;
        Se         = 1'b0;
        Alusrca    = 2'b00;
        Alusrcb    = 2'b00;
        Aluc       = ALU_ADD;
        Pcsrc      = 2'b00;
        Illegal    = 1'b0;
        state_next = S_IF;
        if (!Clr) begin
            Regrt   = !is_rtype;
            Reg2reg = is_lw;
            Se      = !is_zext;
            case (state)
                S_IF: begin
                    Mrd     = 1'b1;
                    Alusrcb = 2'b01;
                    if (Mrdy) begin
                        Irwrite    = 1'b1;
                        Pcwrite    = 1'b1;
                        state_next = S_ID;
                    end else begin
                        state_next = S_IF;
                    end
                end
                S_ID: begin
                    Alusrcb = 2'b11;
                    if (!is_legal) begin
                        Illegal = 1'b1;
                    end else if (is_j || is_jal) begin
                        Pcwrite = 1'b1;
                        Pcsrc   = 2'b11;
                        Wreg    = is_jal;
                        Jal     = is_jal;
                    end else if (is_jr) begin
                        Pcwrite = 1'b1;
                        Pcsrc   = 2'b10;
                    end else begin
                        state_next = S_EX;
                    end
                end
                // ALU inputs stay on the EX operation through MEM/WB so the
                // every-cycle Aluout latch keeps holding the address/result.
                S_EX, S_MEM, S_WB: begin
                    Alusrca = ex_srca;
                    Alusrcb = ex_srcb;
                    Aluc    = ex_aluc;
                    if (state == S_EX) begin
                        if (is_beq || is_bne) begin
                            Pcwrite    = br_taken;
                            Pcsrc      = br_taken ? 2'b01 : 2'b00;
                            state_next = S_IF;
                        end else if (is_lw || is_sw) begin
                            state_next = S_MEM;
                        end else begin
                            state_next = S_WB;
                        end
                    end else if (state == S_MEM) begin
                        Iord = 1'b1;
                        if (is_lw) begin
                            Mrd        = 1'b1;
                            state_next = Mrdy ? S_WB : S_MEM;
                        end else if (is_sw) begin
                            Wmem       = 1'b1;
                            state_next = Mrdy ? S_IF : S_MEM;
                        end
                    end else begin
                        Wreg = 1'b1;
                    end
                end
                default: state_next = S_IF;
            endcase
        end
    end

    assign State   = state;
    assign waiting = !Mrdy && (state == S_IF || state == S_MEM);
    assign cnt_inc = {1'b0, wait_cnt} + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state    <= S_IF;
            wait_cnt <= '0;
            Timeout  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting && cnt_inc <= CNT_LIM) begin
                wait_cnt <= cnt_inc[CNT_W-1:0];
            end
            if (waiting && state_next == state && cnt_inc >= CNT_LIM) begin
                Timeout <= 1'b1;
            end
        end
    end

endmodule
